// File: rtl/ex_wb_stage_pkg.sv
// Shared pipeline types for the EX/WB boundary: writeback slot record and
// the load-wait state machine encoding.
package ex_wb_stage_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned XLEN_DEF   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN_DEF-1:0]   data;
    logic                  valid;
  } wb_slot_t;

  typedef enum logic [0:0] {
    StRun,
    StWaitLoad
  } wb_state_e;

endpackage

// File: rtl/ex_wb_stage.sv
// EX/WB pipeline register for the IXU1, IXU2 and LSU slots. Holds a load
// bundle in WB until its data-memory response (or a timeout) and stalls the pipe.
module ex_wb_stage
  import ex_wb_stage_pkg::*;
#(
  parameter int unsigned LOAD_TIMEOUT = 255,
  parameter int unsigned XLEN         = XLEN_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ixu1_ex_valid,
  input  logic [REG_ADDR_W-1:0] ixu1_ex_rd,
  input  logic [XLEN-1:0]       ixu1_ex_result,
  input  logic                  ixu2_ex_valid,
  input  logic [REG_ADDR_W-1:0] ixu2_ex_rd,
  input  logic [XLEN-1:0]       ixu2_ex_result,
  input  logic                  lsu_ex_valid,
  input  logic [REG_ADDR_W-1:0] lsu_ex_rd,
  input  logic                  lsu_ex_is_load,
  input  logic                  lsu_ex_is_store,
  input  logic [XLEN-1:0]       lsu_ex_result,
  input  logic                  flush,
  input  logic                  dmem_rsp_valid,
  input  logic [XLEN-1:0]       dmem_rsp_data,
  output logic [REG_ADDR_W-1:0] ixu1_wb_rd,
  output logic [REG_ADDR_W-1:0] ixu2_wb_rd,
  output logic [REG_ADDR_W-1:0] lsu_wb_rd,
  output logic [XLEN-1:0]       ixu1_wb_data,
  output logic [XLEN-1:0]       ixu2_wb_data,
  output logic [XLEN-1:0]       lsu_wb_data,
  output logic                  lsu_wb_is_load,
  output logic                  rf_ixu1_we,
  output logic                  rf_ixu2_we,
  output logic                  rf_lsu_we,
  output logic                  stall_req,
  output logic                  load_timeout_err
);

  localparam logic [7:0] TimeoutCnt = LOAD_TIMEOUT[7:0];

  wb_slot_t  ixu1_q, ixu1_d;
  wb_slot_t  ixu2_q, ixu2_d;
  wb_slot_t  lsu_q, lsu_d;
  logic      is_load_q, is_load_d;
  logic      first_q, first_d;
  logic      err_q, err_d;
  wb_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  logic load_pend;
  logic timeout_now;
  logic load_done;
  logic capture;

  // A load bundle can only leave WB in the cycle it completes, so "load in WB"
  // is equivalent to "load pending".
  always_comb begin
    load_pend   = is_load_q;
    timeout_now = load_pend && (state_q == StWaitLoad) && !dmem_rsp_valid &&
                  (cnt_q == TimeoutCnt);
    load_done   = load_pend && (dmem_rsp_valid || timeout_now);
    stall_req   = load_pend && !dmem_rsp_valid && !timeout_now;
    capture     = !stall_req;
  end

  always_comb begin
    ixu1_d    = ixu1_q;
    ixu2_d    = ixu2_q;
    lsu_d     = lsu_q;
    is_load_d = is_load_q;
    first_d   = capture;
    err_d     = err_q | timeout_now;
    if (capture) begin
      ixu1_d.valid = ixu1_ex_valid && !flush;
      ixu1_d.rd    = ixu1_d.valid ? ixu1_ex_rd : '0;
      ixu1_d.data  = ixu1_ex_result;
      ixu2_d.valid = ixu2_ex_valid && !flush;
      ixu2_d.rd    = ixu2_d.valid ? ixu2_ex_rd : '0;
      ixu2_d.data  = ixu2_ex_result;
      lsu_d.valid  = lsu_ex_valid && !flush;
      lsu_d.rd     = (lsu_d.valid && !lsu_ex_is_store) ? lsu_ex_rd : '0;
      lsu_d.data   = lsu_ex_is_load ? '0 : lsu_ex_result;
      is_load_d    = lsu_d.valid && lsu_ex_is_load;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StRun: begin
        if (load_pend && !dmem_rsp_valid) begin
          state_d = StWaitLoad;
          cnt_d   = 8'd1;
        end
      end
      StWaitLoad: begin
        if (load_done) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ixu1_q    <= '0;
      ixu2_q    <= '0;
      lsu_q     <= '0;
      is_load_q <= 1'b0;
      first_q   <= 1'b0;
      err_q     <= 1'b0;
      state_q   <= StRun;
      cnt_q     <= '0;
    end else begin
      ixu1_q    <= ixu1_d;
      ixu2_q    <= ixu2_d;
      lsu_q     <= lsu_d;
      is_load_q <= is_load_d;
      first_q   <= first_d;
      err_q     <= err_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    ixu1_wb_rd       = ixu1_q.rd;
    ixu1_wb_data     = ixu1_q.data;
    ixu2_wb_rd       = ixu2_q.rd;
    ixu2_wb_data     = ixu2_q.data;
    lsu_wb_rd        = lsu_q.rd;
    lsu_wb_is_load   = is_load_q;
    load_timeout_err = err_q;
    // Load data is bypassed straight from the response; a timeout writes zero.
    if (timeout_now) begin
      lsu_wb_data = '0;
    end else if (load_pend && dmem_rsp_valid) begin
      lsu_wb_data = dmem_rsp_data;
    end else begin
      lsu_wb_data = lsu_q.data;
    end
    rf_ixu1_we = first_q && ixu1_q.valid && (ixu1_q.rd != '0);
    rf_ixu2_we = first_q && ixu2_q.valid && (ixu2_q.rd != '0);
    rf_lsu_we  = (lsu_q.rd != '0) &&
                 (is_load_q ? load_done : (first_q && lsu_q.valid));
  end

endmodule
